gen_controller: RTL and testbench
=================================

GEN_CONTROLLER -- requirements
Module: gen_controller

Interface
REQ-001 SHALL have parameter NUM_POS, default 4: positions (rows) per generation, legal range 1..2^POS_W.
REQ-002 SHALL have parameter POS_W, default 2: width of pos.
REQ-003 SHALL have parameter RUN_CYCLES, default 1: cycles the run strobe is held per position, legal range >=1.
REQ-004 SHALL have parameter GEN_W, default 16: width of gen_count.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 SHALL have port enable  input  1  level: run generations back-to-back while high.
REQ-008 SHALL have port step  input  1  single-cycle pulse: run exactly one generation from IDLE.
REQ-009 SHALL have port write_array  output  1  strobe: load cell array for current pos.
REQ-010 SHALL have port run  output  1  strobe: evaluate rules for current pos.
REQ-011 SHALL have port write_mem  output  1  strobe: write result back to memory for current pos.
REQ-012 SHALL have port pos  output  POS_W  current position index.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port gen_done  output  1  one-cycle pulse on the last write_mem of a generation.
REQ-015 SHALL have port gen_count  output  GEN_W  completed-generation count.

Function
REQ-016 SHALL implement states IDLE, SETTLE, WR_ARRAY, RUN, WR_MEM; all outputs SHALL be registered or decoded from state only (Moore).
REQ-017 IDLE: all strobes 0, pos = 0; leave to SETTLE on the edge where enable=1 or step=1.
REQ-018 SETTLE: exactly 1 cycle, all strobes 0, then WR_ARRAY.
REQ-019 WR_ARRAY: exactly 1 cycle, write_array=1 only, then RUN.
REQ-020 RUN: exactly RUN_CYCLES consecutive cycles, run=1 only, counted by an internal counter cleared on RUN entry, then WR_MEM.
REQ-021 WR_MEM: exactly 1 cycle, write_mem=1 only.
REQ-022 At most one of write_array, run, write_mem SHALL be high in any cycle.
REQ-023 pos SHALL be constant from SETTLE through WR_MEM of the same position.
REQ-024 After WR_MEM with pos < NUM_POS-1: pos increments by 1, next state SETTLE.
REQ-025 After WR_MEM with pos = NUM_POS-1: gen_done=1 during that WR_MEM cycle; gen_count increments at its end; pos returns to 0; next state SETTLE if enable=1 at that edge, else IDLE.
REQ-026 Generation length SHALL be NUM_POS*(3+RUN_CYCLES) cycles; defaults give 16 cycles, 4 per position.
REQ-027 enable falling mid-generation SHALL NOT abort it; the generation completes, then IDLE.
REQ-028 step SHALL be ignored when busy=1 or enable=1; step and enable both high in IDLE start one generation that continues while enable stays high.
REQ-029 gen_count SHALL wrap from 2^GEN_W-1 to 0 without any flag.
REQ-030 NUM_POS=1: pos SHALL stay 0 and every WR_MEM SHALL pulse gen_done.

Reset
REQ-031 reset=0 SHALL asynchronously force IDLE, pos=0, gen_count=0, RUN counter=0, all strobes, busy and gen_done to 0, including mid-generation.
REQ-032 After reset deasserts, the first state change SHALL occur on a rising edge with enable or step sampled high; no partial generation resumes.

Verification
REQ-033 Defaults, enable=1 held from reset release -> per position 4-cycle pattern none/write_array/run/write_mem, pos 0,1,2,3, gen_done on cycle 16, gen_count=1, pos=0 and SETTLE on cycle 17.
REQ-034 RUN_CYCLES=3, NUM_POS=5, POS_W=3, one step pulse -> run high 3 consecutive cycles per position, pos 0..4, gen_done after 30 cycles, then IDLE, busy=0, gen_count=1.
REQ-035 enable=1, dropped during pos=2 of generation 0 -> generation completes through pos=3 write_mem, gen_count=1, returns to IDLE; step pulses while busy have no effect.
REQ-036 reset=0 asserted mid-cycle during RUN at pos=2 -> outputs 0 immediately without a clock edge, gen_count=0; after release with enable=0 stays IDLE.
REQ-037 GEN_W=2, enable=1 for 5 generations -> gen_count 1,2,3,0,1; strobes mutually exclusive in every cycle.

Source files
------------

// File: rtl/gen_controller.sv
// Generation sequencer: walks NUM_POS positions per generation, issuing
// write_array / run / write_mem strobes for each one, and counts the
// generations it has completed. All outputs are decoded from registered state.
module gen_controller #(
  parameter int unsigned NUM_POS    = 4,
  parameter int unsigned POS_W      = 2,
  parameter int unsigned RUN_CYCLES = 1,
  parameter int unsigned GEN_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             step,
  output logic             write_array,
  output logic             run,
  output logic             write_mem,
  output logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             gen_done,
  output logic [GEN_W-1:0] gen_count
);

  localparam int unsigned RunW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [RunW-1:0]  RunLast = RunW'(RUN_CYCLES - 1);
  localparam logic [POS_W-1:0] PosLast = POS_W'(NUM_POS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StWrArray,
    StRun,
    StWrMem
  } state_e;

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic [RunW-1:0]  run_cnt_q, run_cnt_d;

  // Next-state: sequence through the per-position phases and advance pos.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    gen_count_d = gen_count_q;
    run_cnt_d   = run_cnt_q;
    case (state_q)
      StIdle: begin
        pos_d = '0;
        // step is only honoured here, so pulses while busy are dropped.
        if (enable || step) begin
          state_d = StSettle;
        end
      end
      StSettle: begin
        state_d = StWrArray;
      end
      StWrArray: begin
        run_cnt_d = '0;
        state_d   = StRun;
      end
      StRun: begin
        if (run_cnt_q == RunLast) begin
          state_d = StWrMem;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      StWrMem: begin
        if (pos_q == PosLast) begin
          pos_d       = '0;
          gen_count_d = gen_count_q + 1'b1;
          // enable is only consulted at generation boundaries.
          state_d     = enable ? StSettle : StIdle;
        end else begin
          pos_d   = pos_q + 1'b1;
          state_d = StSettle;
        end
      end
      default: begin
        state_d = StIdle;
        pos_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pos_q       <= '0;
      gen_count_q <= '0;
      run_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      gen_count_q <= gen_count_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    write_array = (state_q == StWrArray);
    run         = (state_q == StRun);
    write_mem   = (state_q == StWrMem);
    busy        = (state_q != StIdle);
    gen_done    = (state_q == StWrMem) && (pos_q == PosLast);
    pos         = pos_q;
    gen_count   = gen_count_q;
  end

endmodule

// File: tb/tb_gen_controller.sv
// Bench for gen_controller: three instances with different parameters share
// clock, reset and inputs; each is compared every cycle against a model that
// tracks only "active" and the cycle offset within the current generation.
module tb_gen_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic step = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic       wa_a, run_a, wm_a, busy_a, gd_a;
  logic [1:0] pos_a;
  logic [15:0] gc_a;
  logic       wa_b, run_b, wm_b, busy_b, gd_b;
  logic [2:0] pos_b;
  logic [15:0] gc_b;
  logic       wa_c, run_c, wm_c, busy_c, gd_c;
  logic [0:0] pos_c;
  logic [1:0] gc_c;

  gen_controller #(.NUM_POS(4), .POS_W(2), .RUN_CYCLES(1), .GEN_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .step(step),
    .write_array(wa_a), .run(run_a), .write_mem(wm_a), .pos(pos_a),
    .busy(busy_a), .gen_done(gd_a), .gen_count(gc_a)
  );

  gen_controller #(.NUM_POS(5), .POS_W(3), .RUN_CYCLES(3), .GEN_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .step(step),
    .write_array(wa_b), .run(run_b), .write_mem(wm_b), .pos(pos_b),
    .busy(busy_b), .gen_done(gd_b), .gen_count(gc_b)
  );

  gen_controller #(.NUM_POS(1), .POS_W(1), .RUN_CYCLES(2), .GEN_W(2)) u_dut_c (
    .clk(clk), .reset(reset), .enable(enable), .step(step),
    .write_array(wa_c), .run(run_c), .write_mem(wm_c), .pos(pos_c),
    .busy(busy_c), .gen_done(gd_c), .gen_count(gc_c)
  );

  // Packed observation: {write_array, run, write_mem, busy, gen_done, pos[7:0], gen_count[15:0]}
  logic [28:0] obs [3];
  assign obs[0] = {wa_a, run_a, wm_a, busy_a, gd_a, 6'd0, pos_a, gc_a};
  assign obs[1] = {wa_b, run_b, wm_b, busy_b, gd_b, 5'd0, pos_b, gc_b};
  assign obs[2] = {wa_c, run_c, wm_c, busy_c, gd_c, 7'd0, pos_c, 14'd0, gc_c};

  // Reference model state and per-instance parameters.
  int np [3] = '{4, 5, 1};
  int rc [3] = '{1, 3, 2};
  int gw [3] = '{16, 16, 2};
  bit act [3];
  int cyc [3];
  int gcnt [3];

  function automatic logic [28:0] expv(int i);
    logic wa, rn, wm, bz, gd;
    logic [7:0] p;
    logic [15:0] g;
    int per, k, ps;
    per = 3 + rc[i];
    wa = 1'b0; rn = 1'b0; wm = 1'b0; bz = 1'b0; gd = 1'b0;
    p = 8'd0;
    g = 16'(gcnt[i]);
    if (act[i]) begin
      k  = cyc[i] % per;
      ps = cyc[i] / per;
      bz = 1'b1;
      wa = (k == 1);
      rn = (k >= 2) && (k < 2 + rc[i]);
      wm = (k == per - 1);
      gd = wm && (ps == np[i] - 1);
      p  = 8'(ps);
    end
    return {wa, rn, wm, bz, gd, p, g};
  endfunction

  // Drive inputs, clock one edge, advance the model, settle 1 time unit.
  task automatic tick(input bit en, input bit st);
    int per;
    enable = en;
    step   = st;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      per = 3 + rc[i];
      if (!reset) begin
        act[i] = 1'b0; cyc[i] = 0; gcnt[i] = 0;
      end else if (!act[i]) begin
        if (en || st) begin
          act[i] = 1'b1; cyc[i] = 0;
        end
      end else if (cyc[i] == np[i] * per - 1) begin
        gcnt[i] = (gcnt[i] + 1) % (1 << gw[i]);
        act[i]  = en;
        cyc[i]  = 0;
      end else begin
        cyc[i]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 2; n++) begin
      tick(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++;
          $display("FAIL reset_hold dut%0d: got %h want %h", i, obs[i], expv(i));
        end
      end
    end
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++;
          $display("FAIL reset_idle dut%0d: got %h want %h", i, obs[i], expv(i));
        end
      end
    end
  endtask

  task automatic test_enable_run();
    int first_done = 0;
    for (int n = 1; n <= 80; n++) begin
      tick(n <= 40, 1'b0);
      if (gd_a && first_done == 0) first_done = n;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++;
          $display("FAIL enable_run dut%0d cyc%0d: got %h want %h", i, n, obs[i], expv(i));
        end
      end
    end
    total++;
    if (first_done !== 16) begin
      bad++;
      $display("FAIL enable_first_done: got cycle %0d want 16", first_done);
    end
  endtask

  task automatic test_step();
    int first_done = 0;
    for (int n = 1; n <= 40; n++) begin
      tick(1'b0, n == 1);
      if (gd_b && first_done == 0) first_done = n;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++;
          $display("FAIL step dut%0d cyc%0d: got %h want %h", i, n, obs[i], expv(i));
        end
      end
    end
    total++;
    if (first_done !== 30) begin
      bad++;
      $display("FAIL step_done_b: got cycle %0d want 30", first_done);
    end
    total++;
    if (busy_b !== 1'b0) begin
      bad++;
      $display("FAIL step_idle_b: got busy %b want 0", busy_b);
    end
  endtask

  task automatic test_enable_drop();
    // Enable for 9 edges puts instance a at pos 2, then drop with step noise.
    for (int n = 1; n <= 50; n++) begin
      tick(n <= 9, (n > 9) && ($urandom_range(3) == 0));
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++;
          $display("FAIL enable_drop dut%0d cyc%0d: got %h want %h", i, n, obs[i], expv(i));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int n = 1; n <= 11; n++) tick(1'b1, 1'b0);
    #3;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0; cyc[i] = 0; gcnt[i] = 0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== expv(i)) begin
        bad++;
        $display("FAIL async_reset dut%0d: got %h want %h", i, obs[i], expv(i));
      end
    end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    #2;
    reset = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++;
          $display("FAIL post_reset dut%0d cyc%0d: got %h want %h", i, n, obs[i], expv(i));
        end
      end
    end
  endtask

  task automatic test_wrap();
    for (int n = 1; n <= 130; n++) begin
      tick(n <= 85, 1'b0);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++;
          $display("FAIL wrap dut%0d cyc%0d: got %h want %h", i, n, obs[i], expv(i));
        end
      end
    end
  endtask

  task automatic test_random();
    bit en = 1'b0;
    for (int n = 1; n <= 1500; n++) begin
      if ($urandom_range(15) == 0) en = ~en;
      tick(en, $urandom_range(9) == 0);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++;
          $display("FAIL random dut%0d cyc%0d: got %h want %h", i, n, obs[i], expv(i));
        end
        total++;
        if ($countones(obs[i][28:26]) > 1) begin
          bad++;
          $display("FAIL strobe_excl dut%0d cyc%0d: got %b want at most one", i, n,
                   obs[i][28:26]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable_run();
    test_step();
    test_enable_drop();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
